time_set_ctrl: RTL and testbench
================================

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter HOUR_MAX, default 23, last hour value before hour wraps to 0.
REQ-002 Parameter MIN_MAX, default 59, last value of minute and second before wrap to 0.
REQ-003 ck  input  1  system clock; all state updates on the falling edge of ck.
REQ-004 rs  input  1  asynchronous active-low reset; rs=0 forces reset state immediately.
REQ-005 tick  input  1  one-cycle count enable (nominal 1 Hz), synchronous to ck.
REQ-006 btn_mode  input  1  mode button level, synchronous and debounced externally; high = pressed.
REQ-007 btn_inc  input  1  increment button level, synchronous and debounced externally; high = pressed.
REQ-008 hour  output  5  current hour, binary, range 0..HOUR_MAX.
REQ-009 min  output  6  current minute, binary, range 0..MIN_MAX.
REQ-010 sec  output  6  current second, binary, range 0..MIN_MAX.
REQ-011 mode  output  2  FSM state: 00 RUN, 01 SET_H, 10 SET_M; 11 never produced.
REQ-012 blank_h  output  1  high = hour digits blanked (blink phase off in SET_H).
REQ-013 blank_m  output  1  high = minute digits blanked (blink phase off in SET_M).
REQ-014 wrap  output  1  one-cycle pulse on full-day rollover.

Function
REQ-015 Button press detection: each button SHALL be registered; press = btn & ~btn_q, exactly one cycle per rising level, held level produces no further presses.
REQ-016 FSM: RUN -mode press-> SET_H -mode press-> SET_M -mode press-> RUN; no other transitions; illegal state 11 SHALL return to RUN next edge.
REQ-017 RUN: on tick, sec increments; sec==MIN_MAX wraps to 0 and carries to min; min==MIN_MAX with carry wraps to 0 and carries to hour; hour==HOUR_MAX with carry wraps to 0.
REQ-018 wrap SHALL be high for exactly the cycle after the tick taking HOUR_MAX:MIN_MAX:MIN_MAX to 00:00:00.
REQ-019 SET_H: inc press increments hour modulo HOUR_MAX+1; min and sec frozen; tick does not count.
REQ-020 SET_M: inc press increments min modulo MIN_MAX+1, no carry into hour; hour and sec frozen.
REQ-021 Transition SET_M -> RUN SHALL clear sec to 0 on the same edge.
REQ-022 Mode press and inc press in the same cycle: mode transition taken, inc ignored.
REQ-023 Tick in same cycle as mode press from RUN: tick counted, mode moves to SET_H.
REQ-024 blink register toggles on every tick while in SET_H or SET_M; forced to 1 on every entry into SET_H and held 1 in RUN.
REQ-025 blank_h = (mode==SET_H) & ~blink; blank_m = (mode==SET_M) & ~blink; both 0 in RUN; all outputs registered except blank_h/blank_m (combinational from registers).
REQ-026 Counters SHALL never hold out-of-range values; widths are fixed, arithmetic modulo as stated, no saturation.

Reset
REQ-027 rs=0: hour=0, min=0, sec=0, mode=00, blink=1, wrap=0, btn registers=0; blank_h=blank_m=0.
REQ-028 Reset asserted mid-count or mid-set SHALL abort immediately; first count after release needs a fresh tick.
REQ-029 Button held high across reset release SHALL not register a press (btn_q loads the held level on first edge).

Verification
REQ-030 Reset then 61 ticks in RUN -> 00:01:01, wrap never high.
REQ-031 Preload 23:59:58 via set mode, 2 ticks in RUN -> 00:00:00, wrap high for one cycle after second tick.
REQ-032 From RUN: mode press, 25 inc presses -> hour=1; mode press, 61 inc presses -> min=1, hour unchanged; mode press -> RUN, sec=0.
REQ-033 btn_inc held high 10 cycles in SET_H -> hour increments by exactly 1; simultaneous mode+inc press in SET_H -> SET_M, hour unchanged.
REQ-034 In SET_M, 4 ticks -> blank_m sequence 1,0,1,0 after each tick, blank_h=0, sec unchanged.
REQ-035 rs pulsed low at 12:34:56 in SET_M -> all outputs at reset values immediately, without waiting for ck.

Source files
------------

// File: rtl/time_set_ctrl_if.sv
// Signal bundle for the time-of-day set controller: count/button inputs
// and the displayed time, mode and blanking outputs.
interface time_set_ctrl_if;
    logic       tick;
    logic       btn_mode;
    logic       btn_inc;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic [1:0] mode;
    logic       blank_h;
    logic       blank_m;
    logic       wrap;

    modport master (
        output tick, btn_mode, btn_inc,
        input  hour, min, sec, mode, blank_h, blank_m, wrap
    );

    modport slave (
        input  tick, btn_mode, btn_inc,
        output hour, min, sec, mode, blank_h, blank_m, wrap
    );
endinterface

// File: rtl/time_set_ctrl.sv
// Clock time keeper with a three-state RUN / SET_H / SET_M setting FSM,
// button edge detection, digit blink control and a day-rollover pulse.
module time_set_ctrl #(
    parameter int unsigned HOUR_MAX = 23,
    parameter int unsigned MIN_MAX  = 59
) (
    input  logic                ck,
    input  logic                rs,
    time_set_ctrl_if.slave      bus
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        SET_H = 2'b01,
        SET_M = 2'b10
    } mode_t;

    localparam logic [4:0] H_LAST = 5'(HOUR_MAX);
    localparam logic [5:0] M_LAST = 6'(MIN_MAX);

    mode_t      state;
    logic [4:0] hour_r;
    logic [5:0] min_r;
    logic [5:0] sec_r;
    logic       blink;
    logic       wrap_r;
    logic       btn_mode_q;
    logic       btn_inc_q;
    logic       armed;
    logic       mode_press;
    logic       inc_press;

    // armed stays low for the first edge after reset so a held button only
    // loads its level into btn_*_q instead of producing a press.
    assign mode_press = bus.btn_mode & ~btn_mode_q & armed;
    assign inc_press  = bus.btn_inc  & ~btn_inc_q  & armed;

    always_ff @(negedge ck or negedge rs) begin
        if (!rs) begin
            state      <= RUN;
            hour_r     <= 5'd0;
            min_r      <= 6'd0;
            sec_r      <= 6'd0;
            blink      <= 1'b1;
            wrap_r     <= 1'b0;
            btn_mode_q <= 1'b0;
            btn_inc_q  <= 1'b0;
            armed      <= 1'b0;
        end else begin
            btn_mode_q <= bus.btn_mode;
            btn_inc_q  <= bus.btn_inc;
            armed      <= 1'b1;
            wrap_r     <= 1'b0;
            case (state)
                RUN: begin
                    blink <= 1'b1;
                    if (bus.tick) begin
                        if (sec_r == M_LAST) begin
                            sec_r <= 6'd0;
                            if (min_r == M_LAST) begin
                                min_r <= 6'd0;
                                if (hour_r == H_LAST) begin
                                    hour_r <= 5'd0;
                                    wrap_r <= 1'b1;
                                end else begin
                                    hour_r <= hour_r + 5'd1;
                                end
                            end else begin
                                min_r <= min_r + 6'd1;
                            end
                        end else begin
                            sec_r <= sec_r + 6'd1;
                        end
                    end
                    if (mode_press) state <= SET_H;
                end
                SET_H: begin
                    if (bus.tick) blink <= ~blink;
                    if (mode_press) begin
                        state <= SET_M;
                    end else if (inc_press) begin
                        hour_r <= (hour_r == H_LAST) ? 5'd0 : hour_r + 5'd1;
                    end
                end
                SET_M: begin
                    if (bus.tick) blink <= ~blink;
                    // Leaving SET_M restarts the minute cleanly at :00.
                    if (mode_press) begin
                        state <= RUN;
                        sec_r <= 6'd0;
                        blink <= 1'b1;
                    end else if (inc_press) begin
                        min_r <= (min_r == M_LAST) ? 6'd0 : min_r + 6'd1;
                    end
                end
                default: begin
                    state <= RUN;
                    blink <= 1'b1;
                end
            endcase
        end
    end

    assign bus.hour    = hour_r;
    assign bus.min     = min_r;
    assign bus.sec     = sec_r;
    assign bus.mode    = state;
    assign bus.wrap    = wrap_r;
    assign bus.blank_h = (state == SET_H) & ~blink;
    assign bus.blank_m = (state == SET_M) & ~blink;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl: a seconds-of-day reference model feeds
// an expectation queue that a posedge monitor drains against the DUT.
module tb_time_set_ctrl;

    localparam int HM  = 23;
    localparam int MM  = 59;
    localparam int DAY = (HM + 1) * (MM + 1) * (MM + 1);

    logic ck = 1'b0;
    logic rs = 1'b1;

    time_set_ctrl_if bus();

    time_set_ctrl #(.HOUR_MAX(HM), .MIN_MAX(MM)) dut (
        .ck  (ck),
        .rs  (rs),
        .bus (bus)
    );

    always #5 ck = ~ck;

    typedef struct packed {
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic [1:0] md;
        logic       bh;
        logic       bm;
        logic       w;
    } obs_t;

    obs_t expq[$];
    obs_t mon_e;
    obs_t mon_a;
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model: time kept as seconds since midnight.
    int t_sec;
    int mmode;
    bit blinkm;
    bit wrapm;
    bit prev_bm;
    bit prev_bi;
    bit first;

    function automatic int get_h();
        return t_sec / ((MM + 1) * (MM + 1));
    endfunction

    function automatic int get_m();
        return (t_sec / (MM + 1)) % (MM + 1);
    endfunction

    function automatic int get_s();
        return t_sec % (MM + 1);
    endfunction

    function automatic void set_hms(int h, int m, int s);
        t_sec = (h * (MM + 1) + m) * (MM + 1) + s;
    endfunction

    function automatic void model_reset();
        t_sec   = 0;
        mmode   = 0;
        blinkm  = 1'b1;
        wrapm   = 1'b0;
        prev_bm = 1'b0;
        prev_bi = 1'b0;
        first   = 1'b1;
    endfunction

    function automatic void model_step(bit tk, bit bmode, bit binc);
        bit pm;
        bit pi;
        pm      = bmode && !prev_bm && !first;
        pi      = binc && !prev_bi && !first;
        prev_bm = bmode;
        prev_bi = binc;
        first   = 1'b0;
        wrapm   = 1'b0;
        case (mmode)
            0: begin
                blinkm = 1'b1;
                if (tk) begin
                    wrapm = (t_sec == DAY - 1);
                    t_sec = (t_sec + 1) % DAY;
                end
                if (pm) mmode = 1;
            end
            1: begin
                if (tk) blinkm = !blinkm;
                if (pm) mmode = 2;
                else if (pi) set_hms((get_h() + 1) % (HM + 1), get_m(), get_s());
            end
            default: begin
                if (tk) blinkm = !blinkm;
                if (pm) begin
                    mmode  = 0;
                    blinkm = 1'b1;
                    set_hms(get_h(), get_m(), 0);
                end else if (pi) begin
                    set_hms(get_h(), (get_m() + 1) % (MM + 1), get_s());
                end
            end
        endcase
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.h  = 5'(get_h());
        o.m  = 6'(get_m());
        o.s  = 6'(get_s());
        o.md = 2'(mmode);
        o.bh = (mmode == 1) && !blinkm;
        o.bm = (mmode == 2) && !blinkm;
        o.w  = wrapm;
        return o;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit tk, input bit bmode, input bit binc);
        bus.tick     = tk;
        bus.btn_mode = bmode;
        bus.btn_inc  = binc;
        model_step(tk, bmode, binc);
        expq.push_back(model_obs());
    endtask

    task automatic step(input bit tk, input bit bmode, input bit binc);
        @(posedge ck);
        #1;
        drive(tk, bmode, binc);
    endtask

    task automatic settle();
        @(negedge ck);
        #1;
    endtask

    task automatic press_mode();
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic press_inc(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 1'b1);
            step(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
    endtask

    // Assert reset between edges, check outputs before any clock edge, then release.
    task automatic do_reset(input bit hold_bm);
        @(posedge ck);
        #1;
        rs           = 1'b0;
        bus.tick     = 1'b0;
        bus.btn_inc  = 1'b0;
        bus.btn_mode = hold_bm;
        #1;
        chk("rst hour",    int'(bus.hour),    0);
        chk("rst min",     int'(bus.min),     0);
        chk("rst sec",     int'(bus.sec),     0);
        chk("rst mode",    int'(bus.mode),    0);
        chk("rst blank_h", int'(bus.blank_h), 0);
        chk("rst blank_m", int'(bus.blank_m), 0);
        chk("rst wrap",    int'(bus.wrap),    0);
        model_reset();
        repeat (2) @(posedge ck);
        #1;
        rs = 1'b1;
        drive(1'b0, hold_bm, 1'b0);
    endtask

    always @(posedge ck) begin
        if (expq.size() > 0) begin
            mon_e = expq.pop_front();
            mon_a = {bus.hour, bus.min, bus.sec, bus.mode, bus.blank_h, bus.blank_m, bus.wrap};
            n_vec++;
            if (mon_a !== mon_e) begin
                n_bad++;
                $display("FAIL scoreboard t=%0t got %0d:%0d:%0d mode=%0d bh=%0b bm=%0b w=%0b expected %0d:%0d:%0d mode=%0d bh=%0b bm=%0b w=%0b",
                         $time, mon_a.h, mon_a.m, mon_a.s, mon_a.md, mon_a.bh, mon_a.bm, mon_a.w,
                         mon_e.h, mon_e.m, mon_e.s, mon_e.md, mon_e.bh, mon_e.bm, mon_e.w);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish (n_vec=%0d)", n_vec);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit tk;
        bit bmode;
        bit binc;
        bus.tick     = 1'b0;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        model_reset();

        // 61 ticks from reset
        do_reset(1'b0);
        ticks(61);
        settle();
        chk("run61 hour", int'(bus.hour), 0);
        chk("run61 min",  int'(bus.min),  1);
        chk("run61 sec",  int'(bus.sec),  1);

        // Preload 23:59:58 and roll the day over
        do_reset(1'b0);
        press_mode();
        press_inc(23);
        press_mode();
        press_inc(59);
        press_mode();
        ticks(58);
        step(1'b1, 1'b0, 1'b0);
        settle();
        chk("pre hour", int'(bus.hour), 23);
        chk("pre min",  int'(bus.min),  59);
        chk("pre sec",  int'(bus.sec),  59);
        chk("pre wrap", int'(bus.wrap), 0);
        step(1'b1, 1'b0, 1'b0);
        settle();
        chk("roll hour", int'(bus.hour), 0);
        chk("roll min",  int'(bus.min),  0);
        chk("roll sec",  int'(bus.sec),  0);
        chk("roll wrap", int'(bus.wrap), 1);
        step(1'b0, 1'b0, 1'b0);
        settle();
        chk("wrap one cycle", int'(bus.wrap), 0);

        // Set hour/minute modulo wrap, sec cleared on return to RUN
        do_reset(1'b0);
        ticks(5);
        press_mode();
        press_inc(25);
        settle();
        chk("seth mode", int'(bus.mode), 1);
        chk("seth hour", int'(bus.hour), 1);
        chk("seth sec frozen", int'(bus.sec), 5);
        press_mode();
        press_inc(61);
        settle();
        chk("setm min",  int'(bus.min),  1);
        chk("setm hour", int'(bus.hour), 1);
        press_mode();
        settle();
        chk("back run mode", int'(bus.mode), 0);
        chk("back run sec",  int'(bus.sec),  0);

        // Held inc counts once; simultaneous mode+inc takes the mode step only
        press_mode();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        settle();
        chk("held inc hour", int'(bus.hour), 2);
        step(1'b0, 1'b1, 1'b1);
        settle();
        chk("mode+inc mode", int'(bus.mode), 2);
        chk("mode+inc hour", int'(bus.hour), 2);
        chk("mode+inc min",  int'(bus.min),  1);
        step(1'b0, 1'b0, 1'b0);

        // Blink in SET_M
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0);
            settle();
            chk("blink blank_m", int'(bus.blank_m), (i % 2 == 0) ? 1 : 0);
            chk("blink blank_h", int'(bus.blank_h), 0);
            chk("blink sec",     int'(bus.sec),     0);
        end
        press_mode();

        // Tick with mode press from RUN is still counted
        step(1'b1, 1'b1, 1'b0);
        settle();
        chk("tick+mode sec",  int'(bus.sec),  1);
        chk("tick+mode mode", int'(bus.mode), 1);
        step(1'b0, 1'b0, 1'b0);
        settle();
        chk("entry blank_h", int'(bus.blank_h), 0);
        press_mode();
        press_mode();

        // Button held across reset release is not a press
        do_reset(1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        settle();
        chk("held rst mode", int'(bus.mode), 0);
        step(1'b0, 1'b0, 1'b0);
        press_mode();
        settle();
        chk("post held press", int'(bus.mode), 1);

        // 12:34:56 in SET_M, then asynchronous reset
        do_reset(1'b0);
        press_mode();
        press_inc(12);
        press_mode();
        press_inc(34);
        press_mode();
        ticks(56);
        press_mode();
        press_mode();
        settle();
        chk("1234 hour", int'(bus.hour), 12);
        chk("1234 min",  int'(bus.min),  34);
        chk("1234 sec",  int'(bus.sec),  56);
        chk("1234 mode", int'(bus.mode), 2);
        do_reset(1'b0);

        // Randomized traffic
        tk    = 1'b0;
        bmode = 1'b0;
        binc  = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 999) == 0) begin
                do_reset(bmode);
            end else begin
                tk = ($urandom_range(0, 2) != 0);
                if ($urandom_range(0, 15) == 0) bmode = ~bmode;
                if ($urandom_range(0, 3) == 0) binc = ~binc;
                step(tk, bmode, binc);
            end
        end

        repeat (3) @(posedge ck);
        #1;
        chk("queue drained", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
